// File: rtl/channel_scanner.sv
// Sequential channel scanner driving an 8:1 mux select, dwelling DWELL cycles per enabled channel.
// Optional build macro SCANNER_STICKY_ALARM_EN makes alarm sticky until rst or an accepted start.
module channel_scanner #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic [7:0] mask,
  input  logic       mux_out,
  output logic [2:0] input_sel,
  output logic       busy,
  output logic       sample_strobe,
  output logic       done,
  output logic [7:0] status,
  output logic       alarm,
  output logic       state_dbg
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic [7:0]    status_q, status_d;
  logic          alarm_q, alarm_d;
  logic [7:0]    above;
  logic [7:0]    sampled;

  // Single-cycle priority search: index of the lowest set bit (0 when none).
  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_bit = 3'(i);
    end
  endfunction

  // start/stop are level commands sampled each edge; no handshake, ignored outside their state.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    status_d = status_q;
    alarm_d  = alarm_q;
    above    = mask_q & (8'hFE << sel_q);
    sampled  = work_q | ({7'd0, mux_out} << sel_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (mask != 8'd0) begin
            mask_d  = mask;
            work_d  = 8'd0;
            sel_d   = lowest_bit(mask);
            cnt_d   = '0;
            state_d = SCAN;
`ifdef SCANNER_STICKY_ALARM_EN
            alarm_d = 1'b0;
`endif
          end else begin
            status_d = 8'd0;
            done_d   = 1'b1;
            alarm_d  = 1'b0;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          strobe_d = 1'b1;
          work_d   = sampled;
          if (above != 8'd0) begin
            sel_d = lowest_bit(above);
            cnt_d = '0;
          end else begin
            status_d = sampled;
            done_d   = 1'b1;
`ifdef SCANNER_STICKY_ALARM_EN
            alarm_d  = alarm_q | (|sampled);
`else
            alarm_d  = |sampled;
`endif
            // Continuous restart re-latches the live mask with no idle gap.
            if (continuous && (mask != 8'd0)) begin
              mask_d = mask;
              work_d = 8'd0;
              sel_d  = lowest_bit(mask);
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= 8'd0;
      work_q   <= 8'd0;
      cnt_q    <= '0;
      sel_q    <= 3'd0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 8'd0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      status_q <= status_d;
      alarm_q  <= alarm_d;
    end
  end

  assign input_sel     = sel_q;
  assign busy          = (state_q == SCAN);
  assign state_dbg     = (state_q == SCAN);
  assign sample_strobe = strobe_q;
  assign done          = done_q;
  assign status        = status_q;
  assign alarm         = alarm_q;

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner (DWELL=4) with a behavioural 8:1 mux driven by a pattern byte.
module tb_channel_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] mask;
  logic       mux_out;
  logic [2:0] input_sel;
  logic       busy;
  logic       sample_strobe;
  logic       done;
  logic [7:0] status;
  logic       alarm;
  logic       state_dbg;
  logic [7:0] pattern;

  int n_tests = 0;
  int n_fail  = 0;
  int strobes;

  channel_scanner #(.DWELL(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .continuous   (continuous),
    .mask         (mask),
    .mux_out      (mux_out),
    .input_sel    (input_sel),
    .busy         (busy),
    .sample_strobe(sample_strobe),
    .done         (done),
    .status       (status),
    .alarm        (alarm),
    .state_dbg    (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  assign mux_out = pattern[input_sel];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"},    input_sel,     3'd0);
    chk({tag, "_busy"},   busy,          1'b0);
    chk({tag, "_strobe"}, sample_strobe, 1'b0);
    chk({tag, "_done"},   done,          1'b0);
    chk({tag, "_status"}, status,        8'h00);
    chk({tag, "_alarm"},  alarm,         1'b0);
    chk({tag, "_state"},  state_dbg,     1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    mask = 8'h00; pattern = 8'h00;
    tick(2);
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick(1);

    // Full mask, channels 2 and 5 high
    mask = 8'hFF; pattern = 8'h24;
    pulse_start();
    chk("t1_busy0", busy, 1'b1);
    chk("t1_sel0", input_sel, 3'd0);
    strobes = 0;
    for (int e = 1; e <= 32; e++) begin
      tick(1);
      if (sample_strobe) strobes++;
      chk($sformatf("t1_sel@%0d", e), input_sel, (e < 32) ? 3'(e / 4) : 3'd7);
      chk($sformatf("t1_strobe@%0d", e), sample_strobe, (e % 4) == 0);
      chk($sformatf("t1_done@%0d", e), done, e == 32);
      chk($sformatf("t1_busy@%0d", e), busy, e < 32);
    end
    chk("t1_strobes", strobes, 8);
    chk("t1_status", status, 8'h24);
    chk("t1_alarm", alarm, 1'b1);
    tick(1);
    chk("t1_done_low", done, 1'b0);

    // Sparse mask: channel 0 then 7, no dwell on skipped channels
    mask = 8'h81; pattern = 8'hFF;
    pulse_start();
    chk("t2_sel0", input_sel, 3'd0);
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      chk($sformatf("t2_sel@%0d", e), input_sel, (e < 4) ? 3'd0 : 3'd7);
      chk($sformatf("t2_done@%0d", e), done, e == 8);
      chk($sformatf("t2_busy@%0d", e), busy, e < 8);
    end
    chk("t2_status", status, 8'h81);
    chk("t2_alarm", alarm, 1'b1);

    // Stop at cycle 10 aborts without done; status keeps 8'h81
    mask = 8'hFF; pattern = 8'h5A;
    pulse_start();
    tick(9);
    chk("t4_busy9", busy, 1'b1);
    chk("t4_sel9", input_sel, 3'd2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("t4_busy_stop", busy, 1'b0);
    chk("t4_done_stop", done, 1'b0);
    chk("t4_strobe_stop", sample_strobe, 1'b0);
    chk("t4_status_kept", status, 8'h81);
    tick(4);
    chk("t4_done_after", done, 1'b0);
    chk("t4_busy_after", busy, 1'b0);
    pulse_start();
    chk("t4_restart_sel", input_sel, 3'd0);
    chk("t4_restart_busy", busy, 1'b1);
    for (int e = 1; e <= 32; e++) begin
      tick(1);
      chk($sformatf("t4_done@%0d", e), done, e == 32);
    end
    chk("t4_status", status, 8'h5A);
    chk("t4_alarm", alarm, 1'b1);

    // Empty mask: immediate done with zero status
    mask = 8'h00;
    pulse_start();
    chk("t3_done", done, 1'b1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_status", status, 8'h00);
    chk("t3_alarm", alarm, 1'b0);
    tick(1);
    chk("t3_done_low", done, 1'b0);
    chk("t3_busy_low", busy, 1'b0);

    // Continuous: scan 1 sees channel 3 high, later scans all low
    continuous = 1'b1; mask = 8'h0F; pattern = 8'h08;
    pulse_start();
    for (int e = 1; e <= 48; e++) begin
      tick(1);
      if (e == 16) pattern = 8'h00;
      if (e == 40) continuous = 1'b0;
      chk($sformatf("t5_done@%0d", e), done, (e % 16) == 0);
      chk($sformatf("t5_busy@%0d", e), busy, e < 48);
      if (e == 16) begin
        chk("t5_status1", status, 8'h08);
        chk("t5_alarm1", alarm, 1'b1);
        chk("t5_sel_restart", input_sel, 3'd0);
      end
      if (e == 32) begin
        chk("t5_status2", status, 8'h00);
`ifdef SCANNER_STICKY_ALARM_EN
        chk("t5_alarm2", alarm, 1'b1);
`else
        chk("t5_alarm2", alarm, 1'b0);
`endif
      end
    end
    chk("t5_sel_hold", input_sel, 3'd3);

    // Reset mid-dwell on channel 4
    mask = 8'hFF; pattern = 8'hFF;
    pulse_start();
    tick(18);
    chk("t6_sel_mid", input_sel, 3'd4);
    chk("t6_busy_mid", busy, 1'b1);
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("t6");
    rst = 1'b0;
    tick(20);
    chk("t6_done_idle", done, 1'b0);
    chk("t6_busy_idle", busy, 1'b0);
    chk("t6_status_idle", status, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
